// File: rtl/mem_stage.sv
// EX/MEM pipeline register and data-memory access stage: captures the EX result,
// runs a req/ack bus access with byte-lane alignment and registers the MEM/WB result.
module mem_stage #(
  parameter int WORD = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validE,
  input  logic            flushM,
  input  logic [WORD-1:0] aluOutE,
  input  logic [WORD-1:0] writeDataE,
  input  logic [REGW-1:0] writeRegAddrE,
  input  logic            regWriteE,
  input  logic            memReadE,
  input  logic            memWriteE,
  input  logic [1:0]      memSizeE,
  input  logic            memSignedE,
  output logic            dReq,
  output logic            dWe,
  output logic [WORD-1:0] dAddr,
  output logic [3:0]      dBe,
  output logic [WORD-1:0] dWdata,
  input  logic            dAck,
  input  logic [WORD-1:0] dRdata,
  output logic            stallM,
  output logic [WORD-1:0] aluOutM,
  output logic [REGW-1:0] writeRegAddrM,
  output logic            regWriteM,
  output logic            memReadM,
  output logic [WORD-1:0] memOutM,
  output logic [REGW-1:0] writeRegAddrW,
  output logic            regWriteW,
  output logic            misalignW
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {EMPTY, PASS, ACCESS} state_t;

  logic            validM;
  logic [WORD-1:0] writeDataM;
  logic            memWriteM;
  logic [1:0]      memSizeM;
  logic            memSignedM;
  state_t          state;
  logic            misalign;
  logic            retire;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] laneEnable(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [WORD-1:0] laneData(input logic [1:0] size, input logic [WORD-1:0] wd);
    case (size)
      SZ_BYTE: return {4{wd[7:0]}};
      SZ_HALF: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [WORD-1:0] loadExtract(input logic [1:0]      size,
                                                  input logic            sgn,
                                                  input logic [1:0]      lane,
                                                  input logic [WORD-1:0] rdata);
    logic        [7:0]      b;
    logic        [15:0]     h;
    logic signed [7:0]      sb;
    logic signed [15:0]     sh;
    logic signed [WORD-1:0] ext;
    b  = rdata[{lane, 3'b000} +: 8];
    h  = lane[1] ? rdata[31:16] : rdata[15:0];
    sb = signed'(b);
    sh = signed'(h);
    case (size)
      SZ_BYTE: ext = sgn ? WORD'(sb) : signed'(WORD'(b));
      SZ_HALF: ext = sgn ? WORD'(sh) : signed'(WORD'(h));
      default: ext = signed'(rdata);
    endcase
    return unsigned'(ext);
  endfunction

  // EX/M boundary: frozen while an access waits for its ack
  always_ff @(posedge clk) begin
    if (rst) begin
      validM        <= 1'b0;
      aluOutM       <= '0;
      writeDataM    <= '0;
      writeRegAddrM <= '0;
      regWriteM     <= 1'b0;
      memReadM      <= 1'b0;
      memWriteM     <= 1'b0;
      memSizeM      <= 2'b00;
      memSignedM    <= 1'b0;
    end else if (!stallM) begin
      aluOutM       <= aluOutE;
      writeDataM    <= writeDataE;
      writeRegAddrM <= writeRegAddrE;
      if (flushM || !validE) begin
        validM     <= 1'b0;
        regWriteM  <= 1'b0;
        memReadM   <= 1'b0;
        memWriteM  <= 1'b0;
        memSizeM   <= 2'b00;
        memSignedM <= 1'b0;
      end else begin
        validM     <= 1'b1;
        regWriteM  <= regWriteE;
        memReadM   <= memReadE;
        memWriteM  <= memWriteE;
        memSizeM   <= memSizeE;
        memSignedM <= memSignedE;
      end
    end
  end

  // The state is a pure decode of the M register; no separate state flop exists.
  always_comb begin
    misalign = (memReadM | memWriteM) & isMisaligned(memSizeM, aluOutM[1:0]);
    if (!validM)
      state = EMPTY;
    else if ((memReadM | memWriteM) && !misalign)
      state = ACCESS;
    else
      state = PASS;
  end

  always_comb begin
    dReq   = 1'b0;
    dWe    = 1'b0;
    dBe    = 4'b0000;
    dWdata = '0;
    stallM = 1'b0;
    retire = 1'b0;
    dAddr  = {aluOutM[WORD-1:2], 2'b00};
    case (state)
      ACCESS: begin
        dReq   = 1'b1;
        dWe    = memWriteM;
        dBe    = laneEnable(memSizeM, aluOutM[1:0]);
        dWdata = laneData(memSizeM, writeDataM);
        stallM = !dAck;
        retire = dAck;
      end
      PASS:    retire = 1'b1;
      default: ;
    endcase
  end

  // M/W boundary: a misaligned access retires without a register write
  always_ff @(posedge clk) begin
    if (rst) begin
      memOutM       <= '0;
      writeRegAddrW <= '0;
      regWriteW     <= 1'b0;
      misalignW     <= 1'b0;
    end else if (retire) begin
      writeRegAddrW <= writeRegAddrM;
      regWriteW     <= regWriteM & !misalign;
      misalignW     <= misalign;
      memOutM       <= (memReadM && !misalign)
                       ? loadExtract(memSizeM, memSignedM, aluOutM[1:0], dRdata)
                       : aluOutM;
    end else begin
      regWriteW <= 1'b0;
      misalignW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-backs are queued at issue and
// matched against the W outputs whenever an instruction becomes visible there.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        validE;
  logic        flushM;
  logic [31:0] aluOutE;
  logic [31:0] writeDataE;
  logic [4:0]  writeRegAddrE;
  logic        regWriteE;
  logic        memReadE;
  logic        memWriteE;
  logic [1:0]  memSizeE;
  logic        memSignedE;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [3:0]  dBe;
  logic [31:0] dWdata;
  logic        dAck;
  logic [31:0] dRdata;
  logic        stallM;
  logic [31:0] aluOutM;
  logic [4:0]  writeRegAddrM;
  logic        regWriteM;
  logic        memReadM;
  logic [31:0] memOutM;
  logic [4:0]  writeRegAddrW;
  logic        regWriteW;
  logic        misalignW;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } wb_t;

  wb_t sb[$];
  wb_t expWb;
  int  checks = 0;
  int  errors = 0;
  int  stallCnt;

  mem_stage #(.WORD(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .validE(validE), .flushM(flushM),
    .aluOutE(aluOutE), .writeDataE(writeDataE), .writeRegAddrE(writeRegAddrE),
    .regWriteE(regWriteE), .memReadE(memReadE), .memWriteE(memWriteE),
    .memSizeE(memSizeE), .memSignedE(memSignedE),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dBe(dBe), .dWdata(dWdata),
    .dAck(dAck), .dRdata(dRdata), .stallM(stallM),
    .aluOutM(aluOutM), .writeRegAddrM(writeRegAddrM), .regWriteM(regWriteM),
    .memReadM(memReadM), .memOutM(memOutM), .writeRegAddrW(writeRegAddrW),
    .regWriteW(regWriteW), .misalignW(misalignW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setE(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mw,
                      input logic [1:0] size, input logic sgn);
    validE = 1'b1; aluOutE = alu; writeDataE = wd; writeRegAddrE = rd;
    regWriteE = rw; memReadE = mr; memWriteE = mw; memSizeE = size; memSignedE = sgn;
  endtask

  task automatic clrE();
    validE = 1'b0; aluOutE = '0; writeDataE = '0; writeRegAddrE = '0;
    regWriteE = 1'b0; memReadE = 1'b0; memWriteE = 1'b0; memSizeE = 2'b00; memSignedE = 1'b0;
  endtask

  task automatic push(input logic [31:0] data, input logic [4:0] rd, input logic rw, input logic mis);
    wb_t e;
    e.data = data; e.rd = rd; e.rw = rw; e.mis = mis;
    sb.push_back(e);
  endtask

  // Every visible retirement must match the oldest queued expectation
  always @(negedge clk) begin
    if (regWriteW || misalignW) begin
      if (sb.size() == 0) begin
        chk("wb_spurious", 32'(regWriteW | misalignW), 32'd0);
      end else begin
        expWb = sb.pop_front();
        chk("wb_data", memOutM, expWb.data);
        chk("wb_rd", 32'(writeRegAddrW), 32'(expWb.rd));
        chk("wb_we", 32'(regWriteW), 32'(expWb.rw));
        chk("wb_mis", 32'(misalignW), 32'(expWb.mis));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1; flushM = 1'b0; dAck = 1'b0; dRdata = '0;
    clrE();
    step(); step();
    rst = 1'b0;
    chk("rst_dReq", 32'(dReq), 32'd0);
    chk("rst_stall", 32'(stallM), 32'd0);
    chk("rst_aluOutM", aluOutM, 32'd0);
    chk("rst_memOutM", memOutM, 32'd0);
    chk("rst_regWriteW", 32'(regWriteW), 32'd0);

    // ALU op
    setE(32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    push(32'h0000_1234, 5'd5, 1'b1, 1'b0);
    step(); clrE();
    chk("alu_aluOutM", aluOutM, 32'h0000_1234);
    chk("alu_wrAddrM", 32'(writeRegAddrM), 32'd5);
    chk("alu_regWriteM", 32'(regWriteM), 32'd1);
    chk("alu_dReq", 32'(dReq), 32'd0);
    step();
    chk("alu_dReq_w", 32'(dReq), 32'd0);
    step();

    // Signed and unsigned byte loads at 0x103, acked in the first M cycle
    for (int s = 1; s >= 0; s--) begin
      setE(32'h0000_0103, 32'd0, 5'(7 + (1 - s)), 1'b1, 1'b1, 1'b0, 2'b00, 1'(s));
      push((s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080, 5'(7 + (1 - s)), 1'b1, 1'b0);
      step(); clrE();
      dRdata = 32'h80FF_0000; dAck = 1'b1;
      #1;
      chk("lb_dReq", 32'(dReq), 32'd1);
      chk("lb_dBe", 32'(dBe), 32'h8);
      chk("lb_dAddr", dAddr, 32'h0000_0100);
      chk("lb_dWe", 32'(dWe), 32'd0);
      chk("lb_stall", 32'(stallM), 32'd0);
      step(); dAck = 1'b0;
    end
    step();

    // Half store at 0x202 with three wait cycles
    setE(32'h0000_0202, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    step(); clrE(); dAck = 1'b0;
    stallCnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stallM) stallCnt++;
      chk("hs_dReq", 32'(dReq), 32'd1);
      chk("hs_dWe", 32'(dWe), 32'd1);
      chk("hs_dBe", 32'(dBe), 32'hC);
      chk("hs_dWdata", dWdata, 32'hBEEF_BEEF);
      chk("hs_dAddr", dAddr, 32'h0000_0200);
      step();
    end
    dAck = 1'b1;
    #1;
    chk("hs_stall_ack", 32'(stallM), 32'd0);
    chk("hs_stallCnt", 32'(stallCnt), 32'd3);
    chk("hs_dBe_ack", 32'(dBe), 32'hC);
    step(); dAck = 1'b0;
    chk("hs_memOutM", memOutM, 32'h0000_0202);
    chk("hs_regWriteW", 32'(regWriteW), 32'd0);
    chk("hs_dReq_after", 32'(dReq), 32'd0);
    step();

    // Misaligned word load at 0x6
    setE(32'h0000_0006, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    push(32'h0000_0006, 5'd9, 1'b0, 1'b1);
    step(); clrE();
    chk("mis_dReq", 32'(dReq), 32'd0);
    chk("mis_stall", 32'(stallM), 32'd0);
    step();
    chk("mis_misalignW", 32'(misalignW), 32'd1);
    step();

    // Reset in the second wait cycle of a load abandons it
    setE(32'h0000_0040, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    step(); clrE(); dAck = 1'b0;
    chk("rl_stall1", 32'(stallM), 32'd1);
    step();
    rst = 1'b1;
    chk("rl_stall2", 32'(stallM), 32'd1);
    step(); rst = 1'b0;
    chk("rl_dReq", 32'(dReq), 32'd0);
    chk("rl_stall", 32'(stallM), 32'd0);
    chk("rl_memReadM", 32'(memReadM), 32'd0);
    chk("rl_regWriteM", 32'(regWriteM), 32'd0);
    chk("rl_aluOutM", aluOutM, 32'd0);
    dAck = 1'b1; dRdata = 32'h0000_0055;
    step(); dAck = 1'b0;
    chk("rl_regWriteW", 32'(regWriteW), 32'd0);
    step();

    // Flushed store becomes a bubble
    setE(32'h0000_0300, 32'h0000_1234, 5'd6, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    flushM = 1'b1;
    step(); flushM = 1'b0; clrE();
    chk("fl_dReq", 32'(dReq), 32'd0);
    chk("fl_regWriteM", 32'(regWriteM), 32'd0);
    chk("fl_stall", 32'(stallM), 32'd0);
    step(); step();

    // Back-to-back word loads at 0x10 and 0x14
    setE(32'h0000_0010, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    push(32'h1111_1111, 5'd10, 1'b1, 1'b0);
    step();
    setE(32'h0000_0014, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    push(32'h2222_2222, 5'd11, 1'b1, 1'b0);
    dRdata = 32'h1111_1111; dAck = 1'b1;
    #1;
    chk("bb_dReq0", 32'(dReq), 32'd1);
    chk("bb_dAddr0", dAddr, 32'h0000_0010);
    step(); clrE();
    dRdata = 32'h2222_2222;
    #1;
    chk("bb_dReq1", 32'(dReq), 32'd1);
    chk("bb_dAddr1", dAddr, 32'h0000_0014);
    chk("bb_stall1", 32'(stallM), 32'd0);
    step(); dAck = 1'b0;
    chk("bb_dReq2", 32'(dReq), 32'd0);
    step();

    // Flush while stalled is ignored
    setE(32'h0000_0020, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    push(32'h3333_3333, 5'd12, 1'b1, 1'b0);
    step(); clrE(); flushM = 1'b1;
    #1;
    chk("fs_stall", 32'(stallM), 32'd1);
    step();
    chk("fs_dReq", 32'(dReq), 32'd1);
    chk("fs_dAddr", dAddr, 32'h0000_0020);
    dAck = 1'b1; dRdata = 32'h3333_3333;
    step(); dAck = 1'b0; flushM = 1'b0;
    step(); step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
